output_writer: RTL and testbench

- Sits directly downstream of the step2 datapath.
- Sequences step2's 3-bit output-select lines across the eight dot-product results, captures the registered 16-bit result stream, and writes each word into the output data memory at consecutive addresses.
- Owns the result-to-memory handshake: accepts a one-cycle "results ready" pulse from the controller, buffers at most one pending request, and reports busy, done and overrun.

---
 rtl/output_writer.sv | 188 ++++++++++++++++++
 tb/tb_output_writer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/output_writer.sv
// Result writer: sequences step2 out_select over the dot results and
// streams each registered result into the output memory at base+k.
//
// Ports:
//   clock, reset_n              clock, async active-low reset
//   results_valid, base_address job request pulse and its base address
//   output_data                 step2 result, one cycle after out_select
//   out_select                  result index driven to step2
//   mem_address/data/we         registered output-memory write port
//   busy, done, overrun         job active, last-write pulse, dropped request
module output_writer #(
   parameter int ADDR_W  = 8,
   parameter int NUM_OUT = 8,
   parameter int DATA_W  = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              results_valid,
   input  logic [ADDR_W-1:0] base_address,
   input  logic [DATA_W-1:0] output_data,
   output logic [2:0]        out_select,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_we,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEL,
      ST_DRAIN
   } state_t;

   localparam logic [2:0] LAST = 3'(NUM_OUT - 1);

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_idx, w_idx_nxt;
   logic              r_drain, w_drain_nxt;
   logic [ADDR_W-1:0] r_base, w_base_nxt;
   logic              r_pend, w_pend_nxt;
   logic [ADDR_W-1:0] r_pend_base, w_pend_base_nxt;
   logic [2:0]        r_last_sel;

   // write pipeline: stage 1 tags the select cycle, stage 2 is the port
   logic              r_v1;
   logic              r_last1;
   logic [ADDR_W-1:0] r_addr1;
   logic              r_we;
   logic              r_done;
   logic              r_ovr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;

   logic w_in_sel;
   logic w_is_last;
   logic w_req;
   logic w_start;
   logic w_ovr;

   assign w_in_sel  = (r_state == ST_SEL);
   assign w_is_last = (r_idx == LAST);
   assign w_req     = r_pend | results_valid;

   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_drain_nxt     = r_drain;
      w_base_nxt      = r_base;
      w_pend_nxt      = r_pend;
      w_pend_base_nxt = r_pend_base;
      w_start         = 1'b0;
      w_ovr           = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (results_valid) begin
               w_state_nxt = ST_SEL;
               w_idx_nxt   = 3'd0;
               w_base_nxt  = base_address;
            end
         end
         ST_SEL: begin
            if (!w_is_last) begin
               w_idx_nxt = r_idx + 3'd1;
            end else if (w_req) begin
               w_start   = 1'b1;
               w_idx_nxt = 3'd0;
            end else begin
               w_state_nxt = ST_DRAIN;
               w_drain_nxt = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (w_req) begin
               w_start     = 1'b1;
               w_state_nxt = ST_SEL;
               w_idx_nxt   = 3'd0;
            end else if (r_drain) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_drain_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // pending request is older, so it always wins the next job
      if (w_start) begin
         w_base_nxt = r_pend ? r_pend_base : base_address;
      end

      if (r_state != ST_IDLE) begin
         if (w_start && r_pend) begin
            w_pend_nxt = results_valid;
            if (results_valid) begin
               w_pend_base_nxt = base_address;
            end
         end else if (results_valid && !w_start) begin
            if (r_pend) begin
               w_ovr = 1'b1;
            end else begin
               w_pend_nxt      = 1'b1;
               w_pend_base_nxt = base_address;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= 3'd0;
         r_drain     <= 1'b0;
         r_base      <= '0;
         r_pend      <= 1'b0;
         r_pend_base <= '0;
         r_last_sel  <= 3'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_drain     <= w_drain_nxt;
         r_base      <= w_base_nxt;
         r_pend      <= w_pend_nxt;
         r_pend_base <= w_pend_base_nxt;
         if (w_in_sel) begin
            r_last_sel <= r_idx;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_v1    <= 1'b0;
         r_last1 <= 1'b0;
         r_addr1 <= '0;
         r_we    <= 1'b0;
         r_done  <= 1'b0;
         r_ovr   <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         r_v1    <= w_in_sel;
         r_last1 <= w_in_sel & w_is_last;
         r_addr1 <= r_base + ADDR_W'(r_idx);
         r_we    <= r_v1;
         r_done  <= r_v1 & r_last1;
         r_ovr   <= w_ovr;
         if (r_v1) begin
            r_addr <= r_addr1;
            r_data <= output_data;
         end
      end
   end

   // DRAIN and IDLE keep the last index so step2 output stays stable
   assign out_select  = w_in_sel ? r_idx : r_last_sel;
   assign mem_address = r_addr;
   assign mem_data    = r_data;
   assign mem_we      = r_we;
   assign done        = r_done;
   assign overrun     = r_ovr;
   assign busy        = (r_state != ST_IDLE) | r_pend | r_v1 | r_we;

endmodule

// File: tb/tb_output_writer.sv
// Directed bench for output_writer: single jobs, address wrap,
// back-to-back jobs, overrun, mid-job reset and a NUM_OUT=4 variant.
module tb_output_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        rv = 1'b0;
   logic [7:0]  base = 8'h00;
   logic [15:0] od = 16'h0;
   logic [2:0]  sel;
   logic [7:0]  maddr;
   logic [15:0] mdata;
   logic        mwe, busy, done, ovr;

   logic        rv4 = 1'b0;
   logic [7:0]  base4 = 8'h00;
   logic [15:0] od4 = 16'h0;
   logic [2:0]  sel4;
   logic [7:0]  maddr4;
   logic [15:0] mdata4;
   logic        mwe4, busy4, done4, ovr4;

   logic [15:0] res [8];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   output_writer #(.ADDR_W(8), .NUM_OUT(8), .DATA_W(16)) u_dut (
      .clock        (clk),
      .reset_n      (rst_n),
      .results_valid(rv),
      .base_address (base),
      .output_data  (od),
      .out_select   (sel),
      .mem_address  (maddr),
      .mem_data     (mdata),
      .mem_we       (mwe),
      .busy         (busy),
      .done         (done),
      .overrun      (ovr)
   );

   output_writer #(.ADDR_W(8), .NUM_OUT(4), .DATA_W(16)) u_dut4 (
      .clock        (clk),
      .reset_n      (rst_n),
      .results_valid(rv4),
      .base_address (base4),
      .output_data  (od4),
      .out_select   (sel4),
      .mem_address  (maddr4),
      .mem_data     (mdata4),
      .mem_we       (mwe4),
      .busy         (busy4),
      .done         (done4),
      .overrun      (ovr4)
   );

   // step2 stand-in: registered result, one cycle after out_select
   always @(posedge clk) begin
      od  <= res[sel];
      od4 <= res[sel4];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // one job at cycle 0; select on 1..8, writes 3..10, done 10
   task automatic run_one(input logic [7:0] b, input int tn);
      logic [7:0] ea;
      @(negedge clk);
      rv   = 1'b1;
      base = b;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         rv = 1'b0;
         if (c <= 8)
            chk($sformatf("t%0d c%0d sel", tn, c), 32'(sel), 32'(c - 1));
         else
            chk($sformatf("t%0d c%0d hold", tn, c), 32'(sel), 32'd7);
         chk($sformatf("t%0d c%0d we", tn, c), 32'(mwe),
             32'(c >= 3 && c <= 10));
         if (c >= 3 && c <= 10) begin
            ea = b + 8'(c - 3);
            chk($sformatf("t%0d c%0d addr", tn, c), 32'(maddr), 32'(ea));
            chk($sformatf("t%0d c%0d data", tn, c), 32'(mdata), 32'(c - 2));
         end
         chk($sformatf("t%0d c%0d done", tn, c), 32'(done), 32'(c == 10));
         chk($sformatf("t%0d c%0d busy", tn, c), 32'(busy), 32'(c <= 10));
         chk($sformatf("t%0d c%0d ovr", tn, c), 32'(ovr), 32'd0);
      end
   endtask

   // job b1 at cycle 0, b2 at t2, optional extra request at t3
   task automatic run_pair(input logic [7:0] b1, input logic [7:0] b2,
                           input int t2, input int t3,
                           input logic [7:0] b3, input int tn);
      logic [7:0] ea;
      int nw;
      nw = 0;
      @(negedge clk);
      rv   = 1'b1;
      base = b1;
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         if (mwe) nw++;
         if (c <= 16)
            chk($sformatf("t%0d c%0d sel", tn, c), 32'(sel), 32'((c - 1) % 8));
         chk($sformatf("t%0d c%0d we", tn, c), 32'(mwe),
             32'(c >= 3 && c <= 18));
         if (c >= 3 && c <= 18) begin
            ea = (c <= 10) ? b1 + 8'(c - 3) : b2 + 8'(c - 11);
            chk($sformatf("t%0d c%0d addr", tn, c), 32'(maddr), 32'(ea));
            chk($sformatf("t%0d c%0d data", tn, c), 32'(mdata),
                32'(((c - 3) % 8) + 1));
         end
         chk($sformatf("t%0d c%0d done", tn, c), 32'(done),
             32'(c == 10 || c == 18));
         chk($sformatf("t%0d c%0d busy", tn, c), 32'(busy), 32'(c <= 18));
         chk($sformatf("t%0d c%0d ovr", tn, c), 32'(ovr),
             32'(t3 != 0 && c == t3 + 1));
         rv   = (c == t2) || (c == t3);
         base = (c == t2) ? b2 : b3;
      end
      chk($sformatf("t%0d nwrites", tn), 32'(nw), 32'd16);
   endtask

   initial begin
      for (int k = 0; k < 8; k++) res[k] = 16'(k + 1);

      // reset state
      repeat (3) @(negedge clk);
      chk("rst sel", 32'(sel), 32'd0);
      chk("rst addr", 32'(maddr), 32'd0);
      chk("rst data", 32'(mdata), 32'd0);
      chk("rst we", 32'(mwe), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst ovr", 32'(ovr), 32'd0);
      chk("rst busy4", 32'(busy4), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle busy", 32'(busy), 32'd0);

      run_one(8'h10, 1);
      run_one(8'hFC, 2);
      run_pair(8'h30, 8'h40, 3, 0, 8'h00, 3);
      run_pair(8'h50, 8'h60, 2, 4, 8'h70, 4);

      // reset mid-job with a pending request queued
      @(negedge clk);
      rv   = 1'b1;
      base = 8'h10;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         rv   = (c == 2);
         base = 8'h99;
      end
      chk("t5 we pre", 32'(mwe), 32'd1);
      chk("t5 busy pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5 we rst", 32'(mwe), 32'd0);
      chk("t5 busy rst", 32'(busy), 32'd0);
      chk("t5 done rst", 32'(done), 32'd0);
      chk("t5 sel rst", 32'(sel), 32'd0);
      rv = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk($sformatf("t5 c%0d we", c), 32'(mwe), 32'd0);
         chk($sformatf("t5 c%0d busy", c), 32'(busy), 32'd0);
      end

      // NUM_OUT=4: select 1..4, writes 3..6, drain 5..6, idle 7
      @(negedge clk);
      rv4   = 1'b1;
      base4 = 8'h20;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         rv4 = 1'b0;
         if (c <= 4)
            chk($sformatf("t6 c%0d sel", c), 32'(sel4), 32'(c - 1));
         else
            chk($sformatf("t6 c%0d hold", c), 32'(sel4), 32'd3);
         chk($sformatf("t6 c%0d we", c), 32'(mwe4), 32'(c >= 3 && c <= 6));
         if (c >= 3 && c <= 6) begin
            chk($sformatf("t6 c%0d addr", c), 32'(maddr4), 32'(8'h20 + c - 3));
            chk($sformatf("t6 c%0d data", c), 32'(mdata4), 32'(c - 2));
         end
         chk($sformatf("t6 c%0d done", c), 32'(done4), 32'(c == 6));
         chk($sformatf("t6 c%0d busy", c), 32'(busy4), 32'(c <= 6));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
